i2c_write_ctrl: RTL and testbench

- I2C master sequencer for single-byte writes (START, 7-bit address + W, ACK, data byte, ACK, STOP).
- Divides CLK_IN to a quarter-SCL-period tick internally and steps the bus phases on that tick.
- Sits between user logic (sensor/display configuration) and the open-drain SCL/SDA pad buffers.
- Replaces the free-running SCL divider where real bus transactions are needed.

---
 rtl/i2c_write_ctrl.sv | 157 +++++++++++++++
 tb/tb_i2c_write_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_ctrl.sv
// i2c_write_ctrl: I2C master that performs one single-byte write per request
// (START, 7-bit address + W, ACK, data byte, ACK, STOP). CLK_IN is divided
// down to a quarter-SCL-period tick, and every bus phase spans four quarters.
//
// Handshake: START is a request that is sampled on each CLK_IN rising edge.
// The request is taken only while the sequencer is idle (BUSY=0), and ADDR/DATA
// are latched on that same edge. START seen while BUSY=1 is ignored. BUSY rises
// on the cycle after the request is taken. When the transaction ends, BUSY drops
// in the same cycle that DONE pulses. A request present in the DONE cycle is
// taken on the next edge.
module i2c_write_ctrl #(
   parameter int FREQ_IN  = 50000000,
   parameter int FREQ_SCL = 100000
) (
   input  logic       CLK_IN,
   input  logic       RST,
   input  logic       START,
   input  logic [6:0] ADDR,
   input  logic [7:0] DATA,
   input  logic       SDA_I,
   output logic       SCL_O,
   output logic       SDA_O,
   output logic       BUSY,
   output logic       DONE,
   output logic       ACK_ERR
);

   localparam int QDIV = FREQ_IN / (4 * FREQ_SCL);
   localparam int CW   = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam logic [CW-1:0] QMAX = CW'(QDIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP
   } state_t;

   state_t        state;
   logic [1:0]    qtr;     // quarter index q0..q3 inside the current phase
   logic [2:0]    bcnt;    // bit index inside the address or data byte
   logic [CW-1:0] cnt;     // CLK_IN cycles inside the current quarter
   logic [7:0]    shreg;   // outgoing byte, current bit at [7]
   logic [7:0]    data_r;  // data byte held until the address has been ACKed
   logic          tick;

   // {SCL, SDA} levels for a given phase and quarter. b is the bit on the wire.
   function automatic logic [1:0] bus_lvl(input state_t st, input logic [1:0] q,
                                          input logic b);
      logic [1:0] lvl;
      case (st)
         S_START:        lvl = (q == 2'd3) ? 2'b00 : ((q == 2'd2) ? 2'b10 : 2'b11);
         S_ADDR, S_DATA: lvl = {(q == 2'd1) || (q == 2'd2), b};
         S_ACK1, S_ACK2: lvl = {(q == 2'd1) || (q == 2'd2), 1'b1};
         S_STOP:         lvl = (q == 2'd0) ? 2'b00 : ((q == 2'd1) ? 2'b10 : 2'b11);
         default:        lvl = 2'b11;
      endcase
      return lvl;
   endfunction

   // Quarter tick: the last CLK_IN cycle of each quarter while a transfer is active.
   always_comb begin
      tick = (state != S_IDLE) && (cnt == QMAX);
   end

   // Quarter counter: held at zero in IDLE and wraps on every tick.
   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else if ((state == S_IDLE) || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Phase sequencer. The pad levels are registered and are set for the quarter being entered.
   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         state   <= S_IDLE;
         qtr     <= 2'd0;
         bcnt    <= 3'd0;
         shreg   <= 8'h00;
         data_r  <= 8'h00;
         SCL_O   <= 1'b1;
         SDA_O   <= 1'b1;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         ACK_ERR <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (START) begin
                  state          <= S_START;
                  qtr            <= 2'd0;
                  bcnt           <= 3'd0;
                  shreg          <= {ADDR, 1'b0};
                  data_r         <= DATA;
                  ACK_ERR        <= 1'b0;
                  BUSY           <= 1'b1;
                  {SCL_O, SDA_O} <= bus_lvl(S_START, 2'd0, 1'b1);
               end
            end
            default: begin
               if (tick) begin
                  if (qtr != 2'd3) begin
                     qtr            <= qtr + 2'd1;
                     {SCL_O, SDA_O} <= bus_lvl(state, qtr + 2'd1, shreg[7]);
                     // The slave's answer is taken at the end of the second SCL-high quarter.
                     if (((state == S_ACK1) || (state == S_ACK2)) && (qtr == 2'd2) && SDA_I) begin
                        ACK_ERR <= 1'b1;
                     end
                  end else begin
                     qtr <= 2'd0;
                     case (state)
                        S_START: begin
                           state          <= S_ADDR;
                           {SCL_O, SDA_O} <= bus_lvl(S_ADDR, 2'd0, shreg[7]);
                        end
                        S_ADDR, S_DATA: begin
                           bcnt  <= bcnt + 3'd1;
                           shreg <= {shreg[6:0], 1'b0};
                           if (bcnt == 3'd7) begin
                              state          <= (state == S_ADDR) ? S_ACK1 : S_ACK2;
                              {SCL_O, SDA_O} <= bus_lvl(S_ACK1, 2'd0, 1'b1);
                           end else begin
                              {SCL_O, SDA_O} <= bus_lvl(state, 2'd0, shreg[6]);
                           end
                        end
                        S_ACK1: begin
                           // An address NACK skips the data byte entirely.
                           if (ACK_ERR) begin
                              state          <= S_STOP;
                              {SCL_O, SDA_O} <= bus_lvl(S_STOP, 2'd0, 1'b1);
                           end else begin
                              state          <= S_DATA;
                              shreg          <= data_r;
                              {SCL_O, SDA_O} <= bus_lvl(S_DATA, 2'd0, data_r[7]);
                           end
                        end
                        S_ACK2: begin
                           state          <= S_STOP;
                           {SCL_O, SDA_O} <= bus_lvl(S_STOP, 2'd0, 1'b1);
                        end
                        default: begin
                           state          <= S_IDLE;
                           BUSY           <= 1'b0;
                           DONE           <= 1'b1;
                           {SCL_O, SDA_O} <= 2'b11;
                        end
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_write_ctrl.sv
// tb_i2c_write_ctrl: randomized bench for i2c_write_ctrl with a bus-level slave,
// an SCL/SDA decoder and a scoreboard of expected transactions.
module tb_i2c_write_ctrl;

   localparam int FREQ_IN  = 400;
   localparam int FREQ_SCL = 25;
   localparam int Q        = FREQ_IN / (4 * FREQ_SCL);
   localparam int W        = 56;  // {done cycle[31:0], ack_err, bit count[4:0], bits[17:0]}

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [6:0] addr;
   logic [7:0] data;
   logic       sda_i;
   logic       scl_o, sda_o, busy, done, ack_err;
   logic       slave_sda = 1'b1;

   // Open-drain SDA: the line is low if either the master or the slave pulls it.
   assign sda_i = sda_o & slave_sda;

   i2c_write_ctrl #(.FREQ_IN(FREQ_IN), .FREQ_SCL(FREQ_SCL)) dut (
      .CLK_IN (clk),
      .RST    (rst),
      .START  (start),
      .ADDR   (addr),
      .DATA   (data),
      .SDA_I  (sda_i),
      .SCL_O  (scl_o),
      .SDA_O  (sda_o),
      .BUSY   (busy),
      .DONE   (done),
      .ACK_ERR(ack_err)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int          n_pass = 0;
   int          n_total = 0;
   logic [W-1:0] exp_q[$];
   logic [1:0]  plan_q[$];
   logic        plan_a1 = 1'b1;  // 1: slave ACKs the address
   logic        plan_a2 = 1'b1;  // 1: slave ACKs the data byte
   int          cyc = 0;
   int          cur_acc = -1;
   int          busy_end = -1;
   int          n_acc = 0;
   int          n_done = 0;
   logic        last_err = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   // ---------------- reference model ----------------
   // Builds the bit sequence a slave should see and the completion time from the write's fields.
   task automatic model_accept(input int e);
      logic [17:0] fr;
      int          nb;
      logic        err;
      int          lat;
      fr = '0;
      nb = 0;
      for (int i = 6; i >= 0; i--) begin fr = {fr[16:0], addr[i]}; nb++; end
      fr = {fr[16:0], 1'b0};     nb++;
      fr = {fr[16:0], ~plan_a1}; nb++;
      if (plan_a1) begin
         for (int i = 7; i >= 0; i--) begin fr = {fr[16:0], data[i]}; nb++; end
         fr = {fr[16:0], ~plan_a2}; nb++;
      end
      err = !(plan_a1 && plan_a2);
      lat = plan_a1 ? (4 + 36 + 36 + 4) * Q : (4 + 36 + 4) * Q;
      exp_q.push_back({32'(e + lat), err, 5'(nb), fr});
      plan_q.push_back({plan_a1, plan_a2});
      cur_acc  = e;
      busy_end = e + lat;
      last_err = err;
      n_acc++;
   endtask

   // Edge-by-edge view of when a request is taken.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         exp_q.delete();
         plan_q.delete();
         busy_end = -1;
         cur_acc  = -1;
         last_err = 1'b0;
      end else if (start && (cyc > busy_end)) begin
         model_accept(cyc);
      end
   end

   // ---------------- slave, bus decoder and scoreboard ----------------
   logic         p_scl = 1'b1, p_sda = 1'b1, in_frame = 1'b0, got_frame = 1'b0;
   logic [19:0]  cur_fr = '0;
   logic [17:0]  last_fr = '0;
   int           cur_n = 0, last_n = 0;
   logic [1:0]   cur_plan = 2'b11;
   logic         bus_sda;
   logic         exp_busy;
   logic [W-1:0] sb_e;

   always @(negedge clk) begin
      bus_sda = sda_o & slave_sda;
      if (rst) begin
         in_frame  = 1'b0;
         got_frame = 1'b0;
         slave_sda = 1'b1;
      end else begin
         if (p_scl && scl_o && p_sda && !bus_sda) begin
            in_frame  = 1'b1;
            cur_fr    = '0;
            cur_n     = 0;
            slave_sda = 1'b1;
            cur_plan  = (plan_q.size() > 0) ? plan_q.pop_front() : 2'b11;
         end else if (p_scl && scl_o && !p_sda && bus_sda && in_frame) begin
            // The SCL rise that sets up STOP is not a data bit.
            in_frame  = 1'b0;
            got_frame = 1'b1;
            last_fr   = cur_fr[18:1];
            last_n    = cur_n - 1;
         end else if (!p_scl && scl_o && in_frame) begin
            cur_fr = {cur_fr[18:0], bus_sda};
            cur_n++;
         end else if (p_scl && !scl_o && in_frame) begin
            if ((cur_n == 8) && cur_plan[1])       slave_sda = 1'b0;
            else if ((cur_n == 17) && cur_plan[0]) slave_sda = 1'b0;
            else                                   slave_sda = 1'b1;
         end

         exp_busy = (cur_acc >= 0) && (cyc >= cur_acc) && (cyc < busy_end);
         check("busy", busy, exp_busy);
         if (!exp_busy) begin
            check("idle_scl", scl_o, 1);
            check("idle_sda", sda_o, 1);
            check("ack_err_hold", ack_err, last_err);
         end
         if (cyc == cur_acc) check("ack_err_clear", ack_err, 0);

         if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
               check("done_unexpected", done, 0);
            end else begin
               sb_e = exp_q.pop_front();
               check("done_cycle", cyc, sb_e[55:24]);
               check("ack_err", ack_err, sb_e[23]);
               check("frame_nbits", got_frame ? last_n : 0, sb_e[22:18]);
               check("frame_bits", last_fr, sb_e[17:0]);
               got_frame = 1'b0;
            end
         end
      end
      p_scl = scl_o;
      p_sda = bus_sda;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      for (int i = 0; i < 1000; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic do_txn(input logic [6:0] a, input logic [7:0] d, input logic p1, input logic p2);
      @(negedge clk);
      addr = a; data = d; plan_a1 = p1; plan_a2 = p2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
   endtask

   task automatic wait_acc(input int target);
      for (int i = 0; i < 1000; i++) begin
         if (n_acc >= target) break;
         @(negedge clk);
      end
      check("accept_timeout", (n_acc >= target) ? 1 : 0, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int d0;
      int gap;
      int acc_t;
      rst = 1'b1; start = 1'b0; addr = '0; data = '0;
      @(negedge clk);
      check("rst_scl", scl_o, 1);
      check("rst_sda", sda_o, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ack_err", ack_err, 0);
      @(posedge clk); #2 rst = 1'b0;

      // directed writes: all ACKed, address NACK, data NACK, then recovery
      do_txn(7'h50, 8'hA5, 1'b1, 1'b1);
      do_txn(7'h50, 8'hA5, 1'b0, 1'b1);
      do_txn(7'h50, 8'hA5, 1'b1, 1'b0);
      do_txn(7'h2C, 8'h3C, 1'b1, 1'b1);

      // request during an active transfer must not disturb it
      @(negedge clk);
      addr = 7'h50; data = 8'h3C; plan_a1 = 1'b1; plan_a2 = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (48) @(negedge clk);
      addr = 7'h7F; data = 8'hFF; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_idle();

      // asynchronous reset in the data byte, then a clean transfer
      @(negedge clk);
      addr = 7'h33; data = 8'hC3; plan_a1 = 1'b1; plan_a2 = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (200) @(negedge clk);
      d0 = n_done;
      #2 rst = 1'b1;
      #1;
      check("arst_scl", scl_o, 1);
      check("arst_sda", sda_o, 1);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      @(posedge clk); @(posedge clk); #2 rst = 1'b0;
      repeat (400) @(negedge clk);
      check("no_done_after_reset", n_done - d0, 0);
      do_txn(7'h50, 8'hA5, 1'b1, 1'b1);

      // START held: back-to-back writes with a single idle cycle between them
      @(negedge clk);
      acc_t = n_acc;
      addr = 7'h11; data = 8'h5A; plan_a1 = 1'b1; plan_a2 = 1'b1; start = 1'b1;
      wait_acc(acc_t + 1);
      @(negedge clk);
      addr = 7'h6E; data = 8'h81; plan_a1 = 1'b1; plan_a2 = 1'b0;
      gap = 0;
      for (int i = 0; i < 1000; i++) begin
         if (n_acc >= acc_t + 2) break;
         if (!busy) gap++;
         @(negedge clk);
      end
      start = 1'b0;
      check("b2b_accept", (n_acc >= acc_t + 2) ? 1 : 0, 1);
      check("b2b_busy_gap", gap, 1);
      wait_idle();

      // randomized writes
      for (int t = 0; t < 14; t++) begin
         repeat ($urandom_range(0, 20)) @(negedge clk);
         do_txn(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      end

      repeat (10) @(negedge clk);
      check("done_count", n_done, n_acc - 1);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
